// File: rtl/lemming_pkg.sv
// Shared types and constants for the lemming stimulus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lemming_pkg;

    // Width of the FSM input vector and of the observed FSM output vector
    localparam int VEC_W      = 6;
    localparam int OBS_W      = 5;
    localparam int HOLD_W_DEF = 8;

    // Bit positions inside a step's input vector
    localparam int VEC_BUMP_LEFT        = 0;
    localparam int VEC_BUMP_RIGHT       = 1;
    localparam int VEC_SMALL_BUMP_LEFT  = 2;
    localparam int VEC_SMALL_BUMP_RIGHT = 3;
    localparam int VEC_GROUND           = 4;
    localparam int VEC_DIG              = 5;

    // Bit positions inside the observed output vector
    localparam int OBS_WALK_LEFT  = 0;
    localparam int OBS_WALK_RIGHT = 1;
    localparam int OBS_AAH        = 2;
    localparam int OBS_DIGGING    = 3;
    localparam int OBS_JUMPING    = 4;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [OBS_W-1:0] obs_t;

    // One step-table entry at the default hold width
    typedef struct packed {
        logic [HOLD_W_DEF-1:0] hold;
        vec_t                  vec;
    } step_t;

    // Lemming standing on the ground, nothing else asserted
    localparam vec_t IDLE_VEC = 6'b010000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_t;

    // Pack the five FSM outputs in observation order
    function automatic obs_t pack_obs(
        input logic walk_left,
        input logic walk_right,
        input logic aah,
        input logic digging,
        input logic jumping
    );
        obs_t o;
        o                 = '0;
        o[OBS_WALK_LEFT]  = walk_left;
        o[OBS_WALK_RIGHT] = walk_right;
        o[OBS_AAH]        = aah;
        o[OBS_DIGGING]    = digging;
        o[OBS_JUMPING]    = jumping;
        return o;
    endfunction

endpackage

// File: rtl/lemming_step_mem.sv
// Step table: NUM_STEPS entries of {hold, vec}, synchronous write, asynchronous read.
// Latency: write visible on the cycle after the write edge; read is combinational.
// Backpressure: none; the owner gates the write strobe.
module lemming_step_mem #(
    parameter int NUM_STEPS = 16,
    parameter int W         = 14,
    parameter int AW        = $clog2(NUM_STEPS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] mem [NUM_STEPS];

    // Table contents are deliberately left unreset; only the write port updates them
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    // Combinational read lets the next step load on the same edge the current one ends
    assign rdat = mem[raddr];

endmodule

// File: rtl/lemming_stim_sequencer.sv
// Plays a programmed step table into the lemming FSM inputs and samples its outputs per step.
// Latency: first vector one cycle after start; back-to-back steps with no gap; obs one cycle after a step ends.
// Backpressure: none; the pause level freezes vector and hold counter, abort returns to idle.
module lemming_stim_sequencer
    import lemming_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int HOLD_W    = 8,
    // Derived from NUM_STEPS; leave at its default
    parameter int AW        = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              areset,
    // Step-table programming
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [VEC_W-1:0]  prog_vec,
    input  logic [HOLD_W-1:0] prog_hold,
    // Playback control
    input  logic [AW-1:0]     num_steps,
    input  logic              loop_en,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    // FSM outputs under observation
    input  logic              walk_left,
    input  logic              walk_right,
    input  logic              aah,
    input  logic              digging,
    input  logic              jumping,
    // FSM inputs being driven
    output logic              bump_left,
    output logic              bump_right,
    output logic              small_bump_left,
    output logic              small_bump_right,
    output logic              ground,
    output logic              dig,
    // Status and observation
    output logic              busy,
    output logic              done,
    output logic              obs_valid,
    output logic [AW-1:0]     obs_step,
    output logic [OBS_W-1:0]  obs_vec
);

    localparam int ENTRY_W = HOLD_W + VEC_W;

    seq_state_t          state;
    logic [AW-1:0]       step;
    logic [AW-1:0]       last_step;
    logic                loop_r;
    logic [HOLD_W-1:0]   cnt;
    vec_t                vec_r;

    logic                mem_we;
    logic [AW-1:0]       rd_addr;
    logic [ENTRY_W-1:0]  rd_dat;
    logic [HOLD_W-1:0]   rd_hold;
    vec_t                rd_vec;
    obs_t                fsm_obs;

    // The table may only change while nothing is being played
    assign mem_we = prog_we && (state == ST_IDLE);

    lemming_step_mem #(
        .NUM_STEPS (NUM_STEPS),
        .W         (ENTRY_W),
        .AW        (AW)
    ) u_step_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdat  ({prog_hold, prog_vec}),
        .raddr (rd_addr),
        .rdat  (rd_dat)
    );

    assign rd_hold = rd_dat[VEC_W +: HOLD_W];
    assign rd_vec  = rd_dat[VEC_W-1:0];

    assign fsm_obs = pack_obs(walk_left, walk_right, aah, digging, jumping);

    // Address of the entry to load at the next step boundary: entry 0 on start or wrap, else step+1
    always_comb begin
        rd_addr = '0;
        if (state != ST_IDLE && step != last_step) begin
            rd_addr = AW'(step + 1'b1);
        end
    end

    // Playback FSM: all outputs registered, abort beats pause which beats step completion
    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= ST_IDLE;
            step      <= '0;
            last_step <= '0;
            loop_r    <= 1'b0;
            cnt       <= '0;
            vec_r     <= IDLE_VEC;
            busy      <= 1'b0;
            done      <= 1'b0;
            obs_valid <= 1'b0;
            obs_step  <= '0;
            obs_vec   <= '0;
        end else begin
            done      <= 1'b0;
            obs_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        step      <= '0;
                        last_step <= num_steps;
                        loop_r    <= loop_en;
                        cnt       <= rd_hold;
                        vec_r     <= rd_vec;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        vec_r <= IDLE_VEC;
                    end else if (pause) begin
                        // Vector and counter simply hold; the cycle does not count toward the step
                        state <= ST_PAUSE;
                    end else begin
                        state <= ST_RUN;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            obs_valid <= 1'b1;
                            obs_step  <= step;
                            obs_vec   <= fsm_obs;
                            if (step == last_step && !loop_r) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                vec_r <= IDLE_VEC;
                            end else begin
                                // rd_addr already points at step+1 or at 0 on wrap
                                step  <= rd_addr;
                                cnt   <= rd_hold;
                                vec_r <= rd_vec;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    vec_r <= IDLE_VEC;
                end
            endcase
        end
    end

    assign bump_left        = vec_r[VEC_BUMP_LEFT];
    assign bump_right       = vec_r[VEC_BUMP_RIGHT];
    assign small_bump_left  = vec_r[VEC_SMALL_BUMP_LEFT];
    assign small_bump_right = vec_r[VEC_SMALL_BUMP_RIGHT];
    assign ground           = vec_r[VEC_GROUND];
    assign dig              = vec_r[VEC_DIG];

endmodule

// File: tb/tb_lemming_stim_sequencer.sv
// Bench for lemming_stim_sequencer with a small walking-lemming model closing the loop.
// Latency: expected obs cycles computed from step holds relative to the start cycle.
// Backpressure: exercised through pause and abort.
module tb_lemming_stim_sequencer;
    import lemming_pkg::*;

    logic       clk = 1'b0;
    logic       areset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [5:0] prog_vec;
    logic [7:0] prog_hold;
    logic [3:0] num_steps;
    logic       loop_en, start, pause, abort;
    logic       walk_left, walk_right, aah, digging, jumping;
    logic       bump_left, bump_right, small_bump_left, small_bump_right, ground, dig;
    logic       busy, done, obs_valid;
    logic [3:0] obs_step;
    logic [4:0] obs_vec;
    logic [5:0] dvec;

    localparam logic [5:0] VA = 6'b010001;
    localparam logic [5:0] VB = 6'b010010;
    localparam logic [5:0] VI = 6'b010000;

    always #5 clk = ~clk;

    lemming_stim_sequencer dut (
        .clk(clk), .areset(areset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_vec(prog_vec), .prog_hold(prog_hold),
        .num_steps(num_steps), .loop_en(loop_en), .start(start), .pause(pause), .abort(abort),
        .walk_left(walk_left), .walk_right(walk_right), .aah(aah), .digging(digging), .jumping(jumping),
        .bump_left(bump_left), .bump_right(bump_right), .small_bump_left(small_bump_left),
        .small_bump_right(small_bump_right), .ground(ground), .dig(dig),
        .busy(busy), .done(done), .obs_valid(obs_valid), .obs_step(obs_step), .obs_vec(obs_vec)
    );

    assign dvec = {dig, ground, small_bump_right, small_bump_left, bump_right, bump_left};

    // Minimal lemming: walks, turns on bumps, falls without ground, digs on request
    typedef enum logic [2:0] {M_WL, M_WR, M_FL, M_FR, M_DL, M_DR} mst_t;
    mst_t mst;
    always @(posedge clk) begin
        if (areset) mst <= M_WL;
        else begin
            case (mst)
                M_WL: if (!ground) mst <= M_FL; else if (dig) mst <= M_DL; else if (bump_left) mst <= M_WR;
                M_WR: if (!ground) mst <= M_FR; else if (dig) mst <= M_DR; else if (bump_right) mst <= M_WL;
                M_FL: if (ground) mst <= M_WL;
                M_FR: if (ground) mst <= M_WR;
                M_DL: if (!ground) mst <= M_FL;
                M_DR: if (!ground) mst <= M_FR;
                default: mst <= M_WL;
            endcase
        end
    end
    assign walk_left  = (mst == M_WL);
    assign walk_right = (mst == M_WR);
    assign aah        = (mst == M_FL) || (mst == M_FR);
    assign digging    = (mst == M_DL) || (mst == M_DR);
    assign jumping    = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        int         step;
        logic [4:0] ov;
        logic       dn;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input int c, input int st, input logic [4:0] ov, input logic dn);
        exp_t e;
        e.cyc = c; e.step = st; e.ov = ov; e.dn = dn;
        sb.push_back(e);
    endtask

    // Every obs_valid must match the oldest expected record; done only alongside a final obs
    always @(negedge clk) begin
        if (areset === 1'b0) begin
            if (obs_valid === 1'b1) begin
                if (sb.size() == 0) chk("obs_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("obs_cycle", cyc, mon_e.cyc);
                    chk("obs_step", 32'(obs_step), 32'(mon_e.step));
                    chk("obs_vec", 32'(obs_vec), 32'(mon_e.ov));
                    chk("obs_done", 32'(done), 32'(mon_e.dn));
                end
            end else if (done !== 1'b0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input string tag, input int c, input logic [5:0] v, input logic b);
        wait_cyc(c);
        @(negedge clk);
        chk({tag, "_vec"}, 32'(dvec), 32'(v));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic prog(input int a, input logic [5:0] v, input logic [7:0] h);
        step_t e;
        e.vec = v; e.hold = h;
        prog_we = 1'b1; prog_addr = 4'(a); prog_vec = e.vec; prog_hold = e.hold;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic sb_drained(input string tag);
        repeat (4) tick();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        areset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_vec = '0; prog_hold = '0;
        num_steps = '0; loop_en = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_vec", 32'(dvec), 32'(VI));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_obs_valid", 32'(obs_valid), 32'd0);
        chk("rst_obs_step", 32'(obs_step), 32'd0);
        chk("rst_obs_vec", 32'(obs_vec), 32'd0);
        areset = 1'b0;
        tick();

        // Two-step non-looping playback
        prog(0, VA, 8'd2);
        prog(1, VB, 8'd0);
        num_steps = 4'd1; loop_en = 1'b0;
        do_start(s);
        push_exp(s + 3, 0, 5'b00010, 1'b0);
        push_exp(s + 4, 1, 5'b00010, 1'b1);
        expect_at("t1_c0", s, VA, 1'b1);
        expect_at("t1_c1", s + 1, VA, 1'b1);
        expect_at("t1_c2", s + 2, VA, 1'b1);
        expect_at("t1_c3", s + 3, VB, 1'b1);
        expect_at("t1_c4", s + 4, VI, 1'b0);
        sb_drained("t1_sb_empty");

        // Ground removed for ten cycles: lemming falls
        prog(0, 6'b000000, 8'd9);
        num_steps = 4'd0;
        do_start(s);
        push_exp(s + 10, 0, 5'b00100, 1'b1);
        expect_at("t2_first", s, 6'b000000, 1'b1);
        expect_at("t2_last", s + 9, 6'b000000, 1'b1);
        expect_at("t2_after", s + 10, VI, 1'b0);
        sb_drained("t2_sb_empty");
        prog(0, VA, 8'd2);
        num_steps = 4'd1;

        // Looping playback, eight steps without gaps, then abort
        loop_en = 1'b1;
        do_start(s);
        for (int k = 0; k < 8; k++)
            push_exp(s + (k / 2) * 4 + ((k % 2) != 0 ? 4 : 3), k % 2, 5'b00010, 1'b0);
        for (int c = 0; c <= 16; c++)
            expect_at("t3_loop", s + c, (c % 4 == 3) ? VB : VA, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_at("t3_abort", s + 17, VI, 1'b0);
        sb_drained("t3_sb_empty");
        loop_en = 1'b0;

        // Five pause cycles inside a four-cycle step
        prog(0, VA, 8'd3);
        num_steps = 4'd0;
        do_start(s);
        push_exp(s + 9, 0, 5'b00010, 1'b1);
        expect_at("t4_c0", s, VA, 1'b1);
        tick();
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
        expect_at("t4_c6", s + 6, VA, 1'b1);
        expect_at("t4_c8", s + 8, VA, 1'b1);
        expect_at("t4_c9", s + 9, VI, 1'b0);
        sb_drained("t4_sb_empty");
        prog(0, VA, 8'd2);
        num_steps = 4'd1;

        // Table write and start while busy are both ignored
        loop_en = 1'b1;
        do_start(s);
        push_exp(s + 3, 0, 5'b00010, 1'b0);
        push_exp(s + 4, 1, 5'b00010, 1'b0);
        push_exp(s + 7, 0, 5'b00010, 1'b0);
        push_exp(s + 8, 1, 5'b00010, 1'b0);
        wait_cyc(s + 1);
        prog(0, 6'b100001, 8'd0);
        expect_at("t5_wrap", s + 4, VA, 1'b1);
        wait_cyc(s + 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_at("t5_norestart", s + 6, VA, 1'b1);
        expect_at("t5_step1", s + 7, VB, 1'b1);
        wait_cyc(s + 9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_at("t5_abort", s + 10, VI, 1'b0);
        sb_drained("t5_sb_empty");
        loop_en = 1'b0;

        // Reset in the middle of a long step 1, then replay
        prog(1, VB, 8'd4);
        num_steps = 4'd1;
        do_start(s);
        push_exp(s + 3, 0, 5'b00010, 1'b0);
        expect_at("t6_c0", s, VA, 1'b1);
        expect_at("t6_c4", s + 4, VB, 1'b1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        expect_at("t6_rst", s + 5, VI, 1'b0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_obs_valid", 32'(obs_valid), 32'd0);
        chk("t6_rst_obs_step", 32'(obs_step), 32'd0);
        chk("t6_rst_obs_vec", 32'(obs_vec), 32'd0);
        chk("t6_rst_sb", 32'(sb.size()), 32'd0);
        tick();
        do_start(s);
        push_exp(s + 3, 0, 5'b00010, 1'b0);
        push_exp(s + 8, 1, 5'b00001, 1'b1);
        expect_at("t6r_c0", s, VA, 1'b1);
        expect_at("t6r_c3", s + 3, VB, 1'b1);
        expect_at("t6r_c7", s + 7, VB, 1'b1);
        expect_at("t6r_c8", s + 8, VI, 1'b0);
        sb_drained("t6_sb_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lemming_stim_sequencer.md
Name: lemming_stim_sequencer

Overview:
- Programmable stimulus controller for the lemming FSM (`top`). It replaces the free-running stimulus generator (`system`) in `kr260_top`.
- Holds a small step table. Each step is a 6-bit input vector plus a hold count.
- On `start`, plays the table into the FSM inputs (bump_left .. dig). At the last cycle of every step it samples the FSM's five outputs for on-board checking.

Parameters:
- NUM_STEPS, 16, depth of the step table (power of 2).
- HOLD_W, 8, width of the per-step hold count.
- AW, $clog2(NUM_STEPS), step-address width (derived; do not override).

Ports:
- clk  in  1  system clock
- areset  in  1  synchronous, active-high reset
- prog_we  in  1  step-table write strobe
- prog_addr  in  AW  step index to write
- prog_vec  in  6  input vector: [0]bump_left [1]bump_right [2]small_bump_left [3]small_bump_right [4]ground [5]dig
- prog_hold  in  HOLD_W  step lasts prog_hold+1 cycles
- num_steps  in  AW  last step index to play; sampled at start
- loop_en  in  1  after the last step, wrap to step 0; sampled at start
- start  in  1  begin playback (single-cycle pulse)
- pause  in  1  level; freezes playback while high
- abort  in  1  single-cycle pulse; returns to IDLE
- walk_left, walk_right, aah, digging, jumping  in  1 each  FSM outputs, sampled for observation
- bump_left, bump_right, small_bump_left, small_bump_right, ground, dig  out  1 each  registered FSM inputs
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse when a non-looping playback finishes
- obs_valid  out  1  one-cycle pulse per completed step
- obs_step  out  AW  index of the completed step
- obs_vec  out  5  {jumping,digging,aah,walk_right,walk_left} sampled at the step's last cycle

Behaviour:
- Reset values:
  - FSM inputs drive IDLE_VEC: ground=1, all others 0.
  - busy=0, done=0, obs_valid=0, obs_step=0, obs_vec=0.
  - State = IDLE.
  - Step table contents are not reset.
- States: IDLE, RUN, PAUSE.
- Table writes:
  - Accepted only in IDLE. Written on the clk edge where prog_we=1.
  - Ignored in RUN/PAUSE.
- IDLE -> RUN on start=1:
  - Capture num_steps and loop_en; step=0; load the hold counter from entry 0.
  - Step-0 vector appears on the FSM outputs the cycle after start (latency 1).
- RUN:
  - Vector is driven for hold+1 consecutive cycles; the counter decrements each cycle.
  - On the last cycle (counter==0), obs_vec/obs_step are captured; obs_valid pulses the following cycle.
  - Next step's vector follows with no gap cycle.
- End of a step where step==num_steps:
  - loop_en=1: step wraps to 0 and playback continues. done does not pulse.
  - loop_en=0: next cycle outputs return to IDLE_VEC, done pulses, busy drops, state -> IDLE. obs_valid for the final step pulses in the same cycle as done.
- RUN -> PAUSE while pause=1:
  - Vector and counter are held; no obs_valid is produced.
  - PAUSE -> RUN when pause=0, resuming with the remaining count.
- abort in RUN or PAUSE:
  - Next cycle: IDLE_VEC, busy=0, no done, no obs_valid.
  - abort has priority over pause and step completion.
- Ignored inputs:
  - start while busy.
  - abort in IDLE.
- areset has priority over everything, including mid-step; it returns all outputs to reset values on the next edge.
- Arithmetic:
  - Hold counter is HOLD_W bits; hold=2^HOLD_W-1 gives 2^HOLD_W cycles.
  - The step pointer wraps at num_steps, not at NUM_STEPS.
- num_steps=0: single-step playback.

Decomposition:
- Package lemming_pkg:
  - step_t struct {hold, vec}.
  - Vector bit-index localparams.
  - IDLE_VEC constant.
  - seq_state_t enum.
- Sub-module lemming_step_mem: NUM_STEPS x (6+HOLD_W) synchronous-write, asynchronous-read array. Combinational read of the next entry keeps the step-to-step gap at zero.
- kr260_top instantiates lemming_stim_sequencer in place of `system`.

Test Plan:
- Load steps 0:{vec=6'b010001, hold=2}, 1:{vec=6'b010010, hold=0}; num_steps=1, loop_en=0; start -> bump_left+ground high for 3 cycles starting 1 cycle after start, then bump_right+ground for 1 cycle, then IDLE_VEC; obs_valid pulses with obs_step=0 then 1; done pulses once, coincident with the second obs_valid.
- Step 0 = {vec=6'b000000 (no ground), hold=9}, FSM previously walking left -> obs_vec=5'b00100 (aah) for step 0.
- Same table with loop_en=1 -> step sequence 0,1,0,1,... for 8 steps with no gap cycles; done never pulses; abort -> IDLE_VEC next cycle, busy=0.
- Raise pause for 5 cycles during a step with hold=3 -> that step is driven for 4+5=9 cycles total; obs_valid delayed by 5 cycles.
- prog_we with a new entry 0 while busy -> ignored: entry 0 replays the old vector after wrap; start while busy -> no restart.
- areset asserted mid-step 1 -> next cycle ground=1, others 0, busy=0, done=0, obs_valid=0; a subsequent start replays from step 0 with the table unchanged.
